// File: rtl/wallace_seq_mult8_pkg.sv
// Shared types and constants for the nibble-sequenced 8x8 multiplier.
package wallace_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int NIB_W     = 4;
  localparam int OP_W      = 8;
  localparam int PROD_W    = 16;
  localparam int NUM_STEPS = 4;

  localparam logic [3:0] SHIFT_S0 = 4'd0;
  localparam logic [3:0] SHIFT_S1 = 4'd4;
  localparam logic [3:0] SHIFT_S2 = 4'd4;
  localparam logic [3:0] SHIFT_S3 = 4'd8;

  // Weight of each nibble pair's partial product within the 16-bit result.
  function automatic logic [3:0] step_shift(input logic [1:0] step);
    case (step)
      2'd0:    step_shift = SHIFT_S0;
      2'd1:    step_shift = SHIFT_S1;
      2'd2:    step_shift = SHIFT_S2;
      default: step_shift = SHIFT_S3;
    endcase
  endfunction

endpackage

// File: rtl/wallace_seq_mult8_if.sv
// Requester-side start/busy/done bus; abort exists only when WALLACE_SEQ_ABORT_EN is defined.
// Handshake: start is sampled on a rising edge only while busy=0; done is a
// one-cycle pulse and prod is valid in that same cycle and holds afterwards.
interface wallace_seq_mult8_if;
  import wallace_seq_pkg::*;

  logic              start;
  logic [OP_W-1:0]   a;
  logic [OP_W-1:0]   b;
  logic              busy;
  logic              done;
  logic [PROD_W-1:0] prod;
`ifdef WALLACE_SEQ_ABORT_EN
  logic              abort;
`endif

  modport master (
    output start, a, b,
`ifdef WALLACE_SEQ_ABORT_EN
    output abort,
`endif
    input  busy, done, prod
  );

  modport slave (
    input  start, a, b,
`ifdef WALLACE_SEQ_ABORT_EN
    input  abort,
`endif
    output busy, done, prod
  );

endinterface

// File: rtl/wallace_seq_mult8_wallace_tree.sv
// Combinational 4x4 unsigned multiplier: four partial-product rows reduced by
// two carry-save stages, then a single carry-propagate add.
module wallace_tree (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] prod
);

  logic [7:0] row0, row1, row2, row3;
  logic [7:0] s1, c1, s2, c2;

  assign row0 = {4'b0, a & {4{b[0]}}};
  assign row1 = {3'b0, a & {4{b[1]}}, 1'b0};
  assign row2 = {2'b0, a & {4{b[2]}}, 2'b0};
  assign row3 = {1'b0, a & {4{b[3]}}, 3'b0};

  // 3:2 compression; the product never exceeds 225 so 8-bit rows never lose carries.
  assign s1 = row0 ^ row1 ^ row2;
  assign c1 = {((row0[6:0] & row1[6:0]) | (row0[6:0] & row2[6:0]) | (row1[6:0] & row2[6:0])), 1'b0};

  assign s2 = s1 ^ c1 ^ row3;
  assign c2 = {((s1[6:0] & c1[6:0]) | (s1[6:0] & row3[6:0]) | (c1[6:0] & row3[6:0])), 1'b0};

  assign prod = s2 + c2;

endmodule

// File: rtl/wallace_seq_mult8.sv
// 8x8 unsigned multiplier time-sharing one 4x4 wallace_tree over four cycles.
// Optional abort input enabled by defining WALLACE_SEQ_ABORT_EN.
module wallace_seq_mult8
  import wallace_seq_pkg::*;
#(
  parameter int CLR_ON_START = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  wallace_seq_mult8_if.slave  bus,
  output state_t              dbg_state,
  output logic [1:0]          dbg_step
);

  state_t            state, state_n;
  logic [1:0]        step, step_n;
  logic [OP_W-1:0]   a_q, a_n;
  logic [OP_W-1:0]   b_q, b_n;
  logic [PROD_W-1:0] acc, acc_n;
  logic [PROD_W-1:0] prod_q, prod_n;
  logic              done_q, done_n;

  logic [NIB_W-1:0]  nib_a, nib_b;
  logic [7:0]        pp;
  logic [PROD_W-1:0] pp_shifted;
  logic [PROD_W-1:0] acc_sum;
  logic              abort_req;

`ifdef WALLACE_SEQ_ABORT_EN
  assign abort_req = bus.abort;
`else
  assign abort_req = 1'b0;
`endif

  // Step bit 0 picks the high nibble of a, step bit 1 the high nibble of b.
  assign nib_a = step[0] ? a_q[7:4] : a_q[3:0];
  assign nib_b = step[1] ? b_q[7:4] : b_q[3:0];

  wallace_tree u_wallace_tree (
    .a    (nib_a),
    .b    (nib_b),
    .prod (pp)
  );

  assign pp_shifted = {8'b0, pp} << step_shift(step);
  assign acc_sum    = acc + pp_shifted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      step   <= 2'd0;
      a_q    <= '0;
      b_q    <= '0;
      acc    <= '0;
      prod_q <= '0;
      done_q <= 1'b0;
    end else begin
      state  <= state_n;
      step   <= step_n;
      a_q    <= a_n;
      b_q    <= b_n;
      acc    <= acc_n;
      prod_q <= prod_n;
      done_q <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    step_n  = step;
    a_n     = a_q;
    b_n     = b_q;
    acc_n   = acc;
    prod_n  = prod_q;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          a_n     = bus.a;
          b_n     = bus.b;
          acc_n   = '0;
          step_n  = 2'd0;
          state_n = RUN;
          if (CLR_ON_START != 0) prod_n = '0;
        end
      end
      RUN: begin
        if (abort_req) begin
          state_n = IDLE;
          step_n  = 2'd0;
        end else if (step == 2'(NUM_STEPS - 1)) begin
          acc_n   = acc_sum;
          prod_n  = acc_sum;
          done_n  = 1'b1;
          step_n  = 2'd0;
          state_n = IDLE;
        end else begin
          acc_n  = acc_sum;
          step_n = step + 2'd1;
        end
      end
      default: begin
        state_n = IDLE;
        step_n  = 2'd0;
      end
    endcase
  end

  assign bus.busy  = (state == RUN);
  assign bus.done  = done_q;
  assign bus.prod  = prod_q;
  assign dbg_state = state;
  assign dbg_step  = step;

endmodule

// File: tb/tb_wallace_seq_mult8.sv
// Directed bench for wallace_seq_mult8: latency, holding, busy-ignore, back-to-back, reset.
module tb_wallace_seq_mult8;
  import wallace_seq_pkg::*;

  logic       clk;
  logic       rst_n;
  state_t     dbg_state;
  logic [1:0] dbg_step;

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];

  wallace_seq_mult8_if bus ();

  wallace_seq_mult8 #(.CLR_ON_START(0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state),
    .dbg_step  (dbg_step)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
    end
  endtask

  // driver: present a request for one edge, queue its expected product
  task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic [15:0] expv);
    bus.start = 1'b1;
    bus.a     = av;
    bus.b     = bv;
    exp_q.push_back(expv);
    tick();
    bus.start = 1'b0;
    bus.a     = $urandom_range(0, 255);
    bus.b     = $urandom_range(0, 255);
  endtask

  // scoreboard: wait for done, check latency in cycles and product against queue head
  task automatic wait_done(input string tag, input int exp_lat);
    int lat;
    logic [15:0] expv;
    logic seen;
    lat  = 0;
    seen = 1'b0;
    for (int i = 1; i <= 12 && !seen; i++) begin
      tick();
      if (bus.done) begin
        lat  = i;
        seen = 1'b1;
      end
    end
    if (!seen) begin
      check({tag, "_timeout"}, 16'd0, 16'd1);
    end else begin
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      check({tag, "_lat"}, 16'(lat), 16'(exp_lat));
      check({tag, "_prod"}, bus.prod, expv);
      check({tag, "_busy_at_done"}, {15'd0, bus.busy}, 16'd0);
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.done) n++;
    end
  endtask

  initial begin
    int nd;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
`ifdef WALLACE_SEQ_ABORT_EN
    bus.abort = 1'b0;
`endif
    #1;
    check("rst_busy", {15'd0, bus.busy}, 16'd0);
    check("rst_done", {15'd0, bus.done}, 16'd0);
    check("rst_prod", bus.prod, 16'h0000);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // max operands, busy held for every cycle before done
    launch(8'hFF, 8'hFF, 16'hFE01);
    check("ff_busy_c1", {15'd0, bus.busy}, 16'd1);
    wait_done("ff", 4);
    tick();
    check("ff_done_one_cycle", {15'd0, bus.done}, 16'd0);
    check("ff_prod_hold", bus.prod, 16'hFE01);

    launch(8'h12, 8'h34, 16'h03A8);
    wait_done("x12x34", 4);
    tick(); tick(); tick();
    check("hold_3a8", bus.prod, 16'h03A8);

    launch(8'h00, 8'hB7, 16'h0000);
    check("hold_during_run", bus.prod, 16'h03A8);
    wait_done("zero", 4);

    // second start while busy must be ignored
    launch(8'hA5, 8'h5A, 16'h3A02);
    bus.start = 1'b1;
    bus.a     = 8'h01;
    bus.b     = 8'h01;
    tick();
    bus.start = 1'b0;
    wait_done("a5x5a", 3);
    count_dones(8, nd);
    check("ignored_no_extra_done", 16'(nd), 16'd0);
    check("ignored_prod", bus.prod, 16'h3A02);

    // back-to-back: new start presented in the done cycle
    launch(8'h07, 8'h09, 16'h003F);
    wait_done("b2b_first", 4);
    launch(8'h03, 8'h05, 16'h000F);
    wait_done("b2b_second", 4);

    // async reset while step2 is being processed
    launch(8'h77, 8'h77, 16'h3751);
    tick();
    tick();
    check("pre_rst_step", {14'd0, dbg_step}, 16'd2);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", {15'd0, bus.busy}, 16'd0);
    check("midrst_done", {15'd0, bus.done}, 16'd0);
    check("midrst_prod", bus.prod, 16'h0000);
    void'(exp_q.pop_back());
    tick();
    rst_n = 1'b1;
    tick();
    launch(8'h10, 8'h10, 16'h0100);
    wait_done("after_rst", 4);

`ifdef WALLACE_SEQ_ABORT_EN
    launch(8'h22, 8'h22, 16'h0484);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("abort_busy", {15'd0, bus.busy}, 16'd0);
    count_dones(8, nd);
    check("abort_no_done", 16'(nd), 16'd0);
    check("abort_prod_kept", bus.prod, 16'h0100);
    void'(exp_q.pop_back());
`endif

    check("queue_empty", 16'(exp_q.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wallace_seq_mult8.md
Name: wallace_seq_mult8

Overview:
Sequencer that computes an 8x8 unsigned product by time-sharing one existing 4x4 wallace_tree multiplier over four cycles. Each cycle it feeds one nibble pair into the multiplier, then shifts and accumulates the partial product. Sits between a requester, using a start/busy/done handshake, and the single combinational wallace_tree instance. Trades area for a 4-cycle latency.

Parameters:
CLR_ON_START, 0, when 1 prod is cleared to 0 on the edge a start is accepted; when 0 prod holds its last result until the next completion.

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request; sampled only when busy=0
a  input  8  multiplicand, latched on start acceptance
b  input  8  multiplier, latched on start acceptance
busy  output  1  high while a multiplication is in progress
done  output  1  one-cycle pulse; prod is valid in the same cycle
prod  output  16  registered 16-bit unsigned result

Behaviour:
- Reset (async, rst_n=0): state=IDLE, step=0, busy=0, done=0, prod=0, accumulator=0, operand latches=0. Takes effect immediately, mid-operation included; the in-flight result is discarded.
- States: IDLE, RUN. 2-bit step counter runs 0..3.
- IDLE with start=1 at edge E0:
  - latch a, b; acc<=0; step<=0; state<=RUN; busy<=1.
  - if CLR_ON_START=1, prod<=0.
- RUN, one step per edge; wallace_tree inputs are muxed by step:
  - step0: a[3:0]*b[3:0], shift 0
  - step1: a[7:4]*b[3:0], shift 4
  - step2: a[3:0]*b[7:4], shift 4
  - step3: a[7:4]*b[7:4], shift 8
- Each step does acc <= acc + (pp << shift), in 16-bit arithmetic. The final sum is always <= 0xFE01, so no overflow and no carry-out is needed.
- Step3 edge (E4):
  - prod <= acc + (pp<<8)
  - done<=1, busy<=0, state<=IDLE
  - Latency: start at E0 gives done and a valid prod after E4, i.e. exactly 4 cycles.
- done is high for exactly one cycle, then cleared on the next edge unless another completion occurs there.
- start while busy=1 is ignored. Operands are not re-latched and there is no queueing.
- Back-to-back: start is accepted in the same cycle done=1 (state is IDLE). The next result follows 4 cycles later, giving a throughput of one product per 4 cycles.
- a and b may change freely after acceptance without affecting the result.
- The wallace_tree inputs are driven from the latched operands only, never directly from the ports.

Optional Feature:
WALLACE_SEQ_ABORT_EN:
- Defined: adds input port abort (1 bit). abort=1 in RUN forces state<=IDLE, busy<=0, step<=0. No done pulse; prod unchanged.
- abort has priority over step3 completion in the same cycle. abort in IDLE is ignored, and start in that same cycle is still accepted.
- Undefined: no abort port; RUN always completes all 4 steps.

Decomposition:
- Package wallace_seq_pkg:
  - state enum {IDLE, RUN}
  - NIB_W=4, OP_W=8, PROD_W=16, NUM_STEPS=4
  - per-step shift constants {0,4,4,8}
- Sub-module: exactly one instance of the existing combinational wallace_tree (a[3:0], b[3:0] -> prod[7:0]). Nibble-select mux and accumulator stay in the top-level module; no other sub-modules.

Test Plan:
- Reset then idle: rst_n=0 mid-simulation -> busy=0, done=0, prod=0 immediately, without waiting for a clock edge.
- a=0xFF, b=0xFF, start 1 cycle -> busy for 4 cycles, done pulse exactly 4 cycles after the start edge, prod=0xFE01.
- a=0x12, b=0x34 -> prod=0x03A8; a=0x00, b=0xB7 -> prod=0x0000; prod holds between completions (CLR_ON_START=0).
- Start a=0xA5, b=0x5A; pulse start again with a=0x01, b=0x01 while busy -> single done, prod=0x3A02, second request ignored.
- Back-to-back: second start (a=0x03, b=0x05) asserted in the done cycle -> next done 4 cycles later with prod=0x000F.
- rst_n low during step2, then released and a=0x10, b=0x10 started -> no stale done, prod=0x0100. With WALLACE_SEQ_ABORT_EN defined, abort at step1 -> no done, prod keeps its previous value.
